// File: rtl/rule90_ctrl.sv
// rule90_ctrl: sequencing controller for the 16-bit rule-90 CA LED datapath.
// Conditions three raw push buttons (sync + debounce + press detect), runs
// a CLEAR/PAUSED/RUNNING state machine and a rate prescaler, and issues
// one-cycle command strobes that the CA register array obeys.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous, active-high reset
//   btn_load        raw load button
//   btn_start_stop  raw run/pause toggle button
//   btn_step        raw single-step button
//   rate_sel[1:0]   step period = TICK_DIV >> rate_sel
//   ca_clear        strobe: datapath clears to zero
//   ca_load         strobe: datapath loads switch data
//   ca_step         strobe: datapath advances one generation
//   running         high while in RUNNING
//   gen_count       generations stepped since last load/clear (wraps)
module rule90_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 25000000,
  parameter int GEN_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_load,
  input  logic             btn_start_stop,
  input  logic             btn_step,
  input  logic [1:0]       rate_sel,
  output logic             ca_clear,
  output logic             ca_load,
  output logic             ca_step,
  output logic             running,
  output logic [GEN_W-1:0] gen_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PS_W = $clog2(TICK_DIV);

  // Button lane indices.
  localparam int B_LOAD = 0;
  localparam int B_SS   = 1;
  localparam int B_STEP = 2;

  typedef enum logic [1:0] {S_CLEAR, S_PAUSED, S_RUNNING} state_t;

  // ---------------- Button conditioning ----------------
  logic [2:0]      raw;
  logic [2:0]      sync1, sync2;
  logic [2:0]      level, level_d;
  logic [2:0]      primed;
  logic [2:0]      press;
  logic [DB_W-1:0] db_cnt [3];
  logic [1:0]      fill;
  logic            fill_done;

  assign raw       = {btn_step, btn_start_stop, btn_load};
  assign fill_done = (fill == 2'd2);

  // A lane is primed once its synchronized input has been seen low after the
  // synchronizer refilled following reset; a button held through reset
  // release therefore must be released before it can produce a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      primed  <= '0;
      fill    <= '0;
      // NOTE: the debounce counters are a tiny register array, not RAM, so
      // they are reset along with everything else to give a known start.
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments here so sync2 takes the old sync1,
      // forming a true two-flop chain regardless of statement order.
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      if (!fill_done) fill <= fill + 2'd1;
      for (int i = 0; i < 3; i++) begin
        primed[i] <= primed[i] | (fill_done & ~sync2[i]);
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Press pulse on accepted rising edge only; releases produce nothing.
  assign press = level & ~level_d & primed;

  // ---------------- Sequencer ----------------
  state_t           state, state_next;
  logic [PS_W-1:0]  presc, presc_next;
  logic [PS_W-1:0]  period_m1;
  logic             terminal;
  logic [GEN_W-1:0] gen_next;
  logic             clear_cmd, load_cmd, step_cmd;

  assign period_m1 = PS_W'((TICK_DIV >> rate_sel) - 1);
  // ">=" rather than "==" so a rate change that shortens the period below
  // the current count still fires on the next cycle instead of wrapping.
  assign terminal  = (presc >= period_m1);

  // State register plus registered strobes and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_CLEAR;
      presc     <= '0;
      gen_count <= '0;
      ca_clear  <= 1'b0;
      ca_load   <= 1'b0;
      ca_step   <= 1'b0;
    end else begin
      state     <= state_next;
      presc     <= presc_next;
      gen_count <= gen_next;
      ca_clear  <= clear_cmd;
      ca_load   <= load_cmd;
      ca_step   <= step_cmd;
    end
  end

  // Next-state and prescaler logic. Priority: load > start_stop > step.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    state_next = state;
    presc_next = presc;
    case (state)
      S_CLEAR: state_next = S_PAUSED;
      S_PAUSED: begin
        if (press[B_LOAD]) begin
          state_next = S_PAUSED;
        end else if (press[B_SS]) begin
          state_next = S_RUNNING;
          presc_next = '0;
        end
      end
      S_RUNNING: begin
        // A press freezes the prescaler and suppresses any coincident step.
        if (press[B_LOAD] || press[B_SS]) begin
          state_next = S_PAUSED;
        end else if (terminal) begin
          presc_next = '0;
        end else begin
          presc_next = presc + PS_W'(1);
        end
      end
      default: state_next = S_PAUSED;
    endcase
  end

  // Command / output logic.
  always_comb begin
    clear_cmd = 1'b0;
    load_cmd  = 1'b0;
    step_cmd  = 1'b0;
    gen_next  = gen_count;
    case (state)
      S_CLEAR: clear_cmd = 1'b1;
      S_PAUSED: begin
        if (press[B_LOAD]) begin
          load_cmd = 1'b1;
          gen_next = '0;
        end else if (!press[B_SS] && press[B_STEP]) begin
          step_cmd = 1'b1;
          gen_next = gen_count + GEN_W'(1);
        end
      end
      S_RUNNING: begin
        if (press[B_LOAD]) begin
          load_cmd = 1'b1;
          gen_next = '0;
        end else if (!press[B_SS] && terminal) begin
          step_cmd = 1'b1;
          gen_next = gen_count + GEN_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign running = (state == S_RUNNING);

endmodule

// File: tb/tb_rule90_ctrl.sv
// Testbench for rule90_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=16, GEN_W=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so the value seen after the k-th edge is "cycle k".
module tb_rule90_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_load, btn_start_stop, btn_step;
  logic [1:0] rate_sel;
  logic       ca_clear, ca_load, ca_step, running;
  logic [3:0] gen_count;

  rule90_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV       (16),
    .GEN_W          (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_load      (btn_load),
    .btn_start_stop(btn_start_stop),
    .btn_step      (btn_step),
    .rate_sel      (rate_sel),
    .ca_clear      (ca_clear),
    .ca_load       (ca_load),
    .ca_step       (ca_step),
    .running       (running),
    .gen_count     (gen_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int excl_bad   = 0;
  int consec_bad = 0;
  logic prev_clear = 1'b0, prev_load = 1'b0, prev_step = 1'b0;
  int step_at[$];
  int load_at[$];
  int clear_at[$];

  typedef struct {
    string      name;
    logic [2:0] btns;    // bit0 load, bit1 start_stop, bit2 step
    logic [1:0] rate;
    int         hold;
    int         window;
    int         n_step;
    int         step_first;
    int         n_load;
    int         load_first;
    int         gen;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (int'(ca_clear) + int'(ca_load) + int'(ca_step) > 1) excl_bad++;
    if ((ca_clear && prev_clear) || (ca_load && prev_load) || (ca_step && prev_step))
      consec_bad++;
    prev_clear = ca_clear;
    prev_load  = ca_load;
    prev_step  = ca_step;
    if (ca_clear) clear_at.push_back(cyc);
    if (ca_load)  load_at.push_back(cyc);
    if (ca_step)  step_at.push_back(cyc);
  endtask

  task automatic run_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic restart();
    cyc = 0;
    step_at.delete();
    load_at.delete();
    clear_at.delete();
  endtask

  function automatic int step_nth(input int i);
    return (i < step_at.size()) ? step_at[i] : -1;
  endfunction

  function automatic int load_nth(input int i);
    return (i < load_at.size()) ? load_at[i] : -1;
  endfunction

  function automatic int clear_nth(input int i);
    return (i < clear_at.size()) ? clear_at[i] : -1;
  endfunction

  task automatic apply_vec(input vec_t v);
    restart();
    rate_sel       = v.rate;
    btn_load       = v.btns[0];
    btn_start_stop = v.btns[1];
    btn_step       = v.btns[2];
    run_until(v.hold);
    btn_load       = 1'b0;
    btn_start_stop = 1'b0;
    btn_step       = 1'b0;
    run_until(v.window);
    check({v.name, " step count"}, step_at.size(), v.n_step);
    if (v.n_step > 0) check({v.name, " step cycle"}, step_nth(0), v.step_first);
    check({v.name, " load count"}, load_at.size(), v.n_load);
    if (v.n_load > 0) check({v.name, " load cycle"}, load_nth(0), v.load_first);
    check({v.name, " gen_count"}, gen_count, v.gen);
    check({v.name, " running"}, running, 0);
  endtask

  int exp_steps[11] = '{23, 39, 55, 71, 87, 91, 95, 99, 106, 110, 114};

  initial begin
    //               name              btns    rate hold win nst first nld first gen
    vecs[0] = '{"step_hold20",    3'b100, 2'd0, 20, 32, 1,  7,    0,  0,    1};
    vecs[1] = '{"step_too_short", 3'b100, 2'd0,  3, 20, 0,  0,    0,  0,    1};
    vecs[2] = '{"step_min_hold",  3'b100, 2'd0,  4, 20, 1,  7,    0,  0,    2};
    vecs[3] = '{"load_paused",    3'b001, 2'd0,  8, 20, 0,  0,    1,  7,    0};
    vecs[4] = '{"load_and_step",  3'b101, 2'd0,  8, 20, 0,  0,    1,  7,    0};
    vecs[5] = '{"step_rate3",     3'b100, 2'd3,  8, 20, 1,  7,    0,  0,    1};

    rst = 1'b1;
    btn_load = 1'b0;
    btn_start_stop = 1'b0;
    btn_step = 1'b0;
    rate_sel = 2'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset ca_clear", ca_clear, 0);
    check("reset running", running, 0);
    check("reset gen_count", gen_count, 0);
    check("reset ca_step", ca_step, 0);

    // Reset release: one ca_clear at the first edge, nothing else for 50 cycles.
    rst = 1'b0;
    restart();
    run_until(50);
    check("clear count", clear_at.size(), 1);
    check("clear cycle", clear_nth(0), 1);
    check("post-clear steps", step_at.size(), 0);
    check("post-clear loads", load_at.size(), 0);
    check("post-clear running", running, 0);
    check("post-clear gen", gen_count, 0);

    // Table-driven single-press vectors in PAUSED.
    for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

    // Bounce 1,0,1,0 (2-cycle segments) then stable 1: exactly one step,
    // seven cycles after the input went stable at cycle 8.
    restart();
    rate_sel = 2'd0;
    btn_step = 1'b1; run_until(2);
    btn_step = 1'b0; run_until(4);
    btn_step = 1'b1; run_until(6);
    btn_step = 1'b0; run_until(8);
    btn_step = 1'b1; run_until(25);
    btn_step = 1'b0; run_until(36);
    check("bounce step count", step_at.size(), 1);
    check("bounce step cycle", step_nth(0), 15);
    check("bounce gen", gen_count, 2);

    // Load to zero the generation counter.
    restart();
    btn_load = 1'b1; run_until(8);
    btn_load = 1'b0; run_until(20);
    check("reload count", load_at.size(), 1);
    check("reload gen", gen_count, 0);

    // RUNNING at rate 0: transition in cycle 7, steps every 16 from cycle 23.
    restart();
    rate_sel = 2'd0;
    btn_start_stop = 1'b1;
    run_until(6);
    check("run not yet", running, 0);
    run_until(7);
    check("run entered", running, 1);
    btn_start_stop = 1'b0;
    run_until(87);
    check("run5 steps", step_at.size(), 5);
    check("run5 gen", gen_count, 5);
    rate_sel = 2'd2;
    run_until(99);
    check("rate2 steps", step_at.size(), 8);
    check("rate2 gen", gen_count, 8);
    rate_sel = 2'd0;
    run_until(105);
    check("rate0 quiet", step_at.size(), 8);
    // Prescaler is at 6, beyond the new terminal 3: step on the next cycle.
    rate_sel = 2'd2;
    run_until(110);
    check("rate shrink steps", step_at.size(), 10);
    check("rate shrink gen", gen_count, 10);
    // Load + start_stop together, press pulse coincides with a terminal.
    run_until(111);
    btn_load = 1'b1;
    btn_start_stop = 1'b1;
    run_until(118);
    check("combo ca_load", ca_load, 1);
    check("combo ca_step", ca_step, 0);
    check("combo running", running, 0);
    check("combo gen", gen_count, 0);
    btn_load = 1'b0;
    btn_start_stop = 1'b0;
    run_until(140);
    check("run total steps", step_at.size(), 11);
    for (int i = 0; i < 11; i++) check($sformatf("run step %0d cycle", i), step_nth(i), exp_steps[i]);
    check("combo load count", load_at.size(), 1);
    check("combo load cycle", load_nth(0), 118);
    check("paused after combo", running, 0);

    // Wrap: period 2, 17 steps then a pause press that coincides with a terminal.
    restart();
    rate_sel = 2'd3;
    btn_start_stop = 1'b1; run_until(8);
    btn_start_stop = 1'b0; run_until(36);
    btn_start_stop = 1'b1; run_until(44);
    btn_start_stop = 1'b0; run_until(60);
    check("wrap steps", step_at.size(), 17);
    check("wrap first", step_nth(0), 9);
    check("wrap last", step_nth(16), 41);
    check("wrap gen", gen_count, 1);
    check("wrap paused", running, 0);

    // Reset mid-run with start_stop held through reset release.
    restart();
    btn_start_stop = 1'b1;
    run_until(19);
    check("pre-reset running", running, 1);
    check("pre-reset gen", gen_count, 7);
    rst = 1'b1;
    #1;
    check("async rst running", running, 0);
    check("async rst gen", gen_count, 0);
    check("async rst ca_step", ca_step, 0);
    check("async rst ca_clear", ca_clear, 0);
    run_until(22);
    rst = 1'b0;
    restart();
    run_until(30);
    check("rerelease clear count", clear_at.size(), 1);
    check("rerelease clear cycle", clear_nth(0), 1);
    check("held no run", running, 0);
    check("held no step", step_at.size(), 0);
    btn_start_stop = 1'b0;
    run_until(48);
    btn_start_stop = 1'b1;
    run_until(54);
    check("repress not yet", running, 0);
    run_until(55);
    check("repress running", running, 1);
    btn_start_stop = 1'b0;
    run_until(60);

    check("strobes exclusive", excl_bad, 0);
    check("strobes single-cycle", consec_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
